// File: rtl/axi_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite register file.
package axi_regfile_pkg;

  localparam int unsigned NREG_DEF = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [NREG_DEF-1:0][DATA_W-1:0] reg_arr_t;

  // Write data beat captured from the W channel
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_beat_t;

  // Merge new data into an old word, byte lane by byte lane
  function automatic logic [DATA_W-1:0] apply_strb(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_regfile.sv
// AXI4-Lite slave exposing NREG 32-bit registers to fabric; independent AW/W
// capture, one outstanding write response and one outstanding read.
module axi_regfile
  import axi_regfile_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned ADDR_W = $clog2(NREG) + 2
) (
  input  logic                           axi_aclk,
  input  logic                           axi_aresetn,
  input  logic [ADDR_W-1:0]              s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_W-1:0]              s_axi_wdata,
  input  logic [STRB_W-1:0]              s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_W-1:0]              s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_W-1:0]              s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NREG-1:0][DATA_W-1:0]    slv_reg,
  input  logic [NREG-1:0][DATA_W-1:0]    slv_read,
  output logic [NREG-1:0]                slv_wr_stb
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  // Write path state
  logic                          aw_held, aw_held_n;
  logic                          w_held, w_held_n;
  logic [IDX_W-1:0]              aw_idx, aw_idx_n;
  wr_beat_t                      w_beat, w_beat_n;
  logic                          commit;
  logic                          bvalid_n, awready_n, wready_n;
  logic [NREG-1:0][DATA_W-1:0]   reg_n;
  logic [NREG-1:0]               stb_n;

  // Read path state
  logic                          rvalid_n, arready_n;
  logic [DATA_W-1:0]             rdata_n;

  // Address LSBs select bytes within a word and play no part in decoding
  logic                          unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;

  // Write path: capture AW/W separately, commit one cycle after both are held
  always_comb begin
    aw_held_n = aw_held;
    w_held_n  = w_held;
    aw_idx_n  = aw_idx;
    w_beat_n  = w_beat;
    bvalid_n  = s_axi_bvalid;
    reg_n     = slv_reg;
    stb_n     = '0;
    commit    = aw_held && w_held;

    if (commit) begin
      reg_n[aw_idx] = apply_strb(slv_reg[aw_idx], w_beat.data, w_beat.strb);
      stb_n[aw_idx] = 1'b1;
      aw_held_n     = 1'b0;
      w_held_n      = 1'b0;
      bvalid_n      = 1'b1;
    end else if (s_axi_bvalid && s_axi_bready) begin
      bvalid_n = 1'b0;
    end

    if (s_axi_awvalid && s_axi_awready) begin
      aw_held_n = 1'b1;
      aw_idx_n  = s_axi_awaddr[ADDR_W-1:2];
    end

    if (s_axi_wvalid && s_axi_wready) begin
      w_held_n      = 1'b1;
      w_beat_n.data = s_axi_wdata;
      w_beat_n.strb = s_axi_wstrb;
    end

    // Readies are registered copies of the next-cycle acceptance condition
    awready_n = !aw_held_n && !bvalid_n;
    wready_n  = !w_held_n && !bvalid_n;
  end

  // Read path: sample fabric value at the AR handshake, hold until accepted
  always_comb begin
    rvalid_n = s_axi_rvalid;
    rdata_n  = s_axi_rdata;
    if (s_axi_arvalid && s_axi_arready) begin
      rvalid_n = 1'b1;
      rdata_n  = slv_read[s_axi_araddr[ADDR_W-1:2]];
    end else if (s_axi_rvalid && s_axi_rready) begin
      rvalid_n = 1'b0;
    end
    arready_n = !rvalid_n;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      w_beat        <= '0;
      slv_reg       <= '0;
      slv_wr_stb    <= '0;
      s_axi_bvalid  <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_arready <= 1'b0;
    end else begin
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      aw_idx        <= aw_idx_n;
      w_beat        <= w_beat_n;
      slv_reg       <= reg_n;
      slv_wr_stb    <= stb_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_awready <= awready_n;
      s_axi_wready  <= wready_n;
      s_axi_rvalid  <= rvalid_n;
      s_axi_rdata   <= rdata_n;
      s_axi_arready <= arready_n;
    end
  end

endmodule

// File: tb/tb_axi_regfile.sv
// Self-checking bench for axi_regfile: transaction-level model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_axi_regfile;
  import axi_regfile_pkg::*;

  logic               clk;
  logic               rstn;
  logic [5:0]         awaddr, araddr;
  logic               awvalid, awready, wvalid, wready;
  logic [31:0]        wdata, rdata;
  logic [3:0]         wstrb;
  logic [1:0]         bresp, rresp;
  logic               bvalid, bready, arvalid, arready, rvalid, rready;
  logic [15:0][31:0]  slv_reg, slv_read;
  logic [15:0]        slv_wr_stb;

  int errors = 0;
  int checks = 0;

  axi_regfile #(.NREG(16), .ADDR_W(6)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .slv_reg(slv_reg), .slv_read(slv_read), .slv_wr_stb(slv_wr_stb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  reg_arr_t    mreg;
  int          aw_q[$];
  logic [35:0] w_q[$];
  bit          e_awrdy, e_wrdy, e_arrdy, e_bvalid, e_rvalid;
  logic [31:0] e_rdata;
  logic [15:0] e_stb;
  bit          started = 0;

  always @(posedge clk) begin
    bit          do_commit, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    int          idx;
    logic [35:0] beat;
    started = 1;
    if (!rstn) begin
      mreg = '0; aw_q.delete(); w_q.delete();
      e_awrdy = 0; e_wrdy = 0; e_arrdy = 0; e_bvalid = 0; e_rvalid = 0;
      e_rdata = '0; e_stb = '0;
    end else begin
      do_commit = (aw_q.size() > 0) && (w_q.size() > 0);
      aw_hs = awvalid && e_awrdy;
      w_hs  = wvalid && e_wrdy;
      ar_hs = arvalid && e_arrdy;
      b_hs  = e_bvalid && bready;
      r_hs  = e_rvalid && rready;
      e_stb = '0;
      if (do_commit) begin
        idx  = aw_q.pop_front();
        beat = w_q.pop_front();
        for (int b = 0; b < 4; b++)
          if (beat[b]) mreg[idx][b*8 +: 8] = beat[4 + b*8 +: 8];
        e_stb[idx] = 1'b1;
        e_bvalid   = 1;
      end else if (b_hs) begin
        e_bvalid = 0;
      end
      if (aw_hs) aw_q.push_back(int'(awaddr[5:2]));
      if (w_hs)  w_q.push_back({wdata, wstrb});
      if (ar_hs) begin
        e_rdata  = slv_read[araddr[5:2]];
        e_rvalid = 1;
      end else if (r_hs) begin
        e_rvalid = 0;
      end
      e_awrdy = (aw_q.size() == 0) && !e_bvalid;
      e_wrdy  = (w_q.size() == 0) && !e_bvalid;
      e_arrdy = !e_rvalid;
    end
  end

  // ---------------- per-cycle compare ----------------
  int b_cnt = 0;
  int stb_cnt[16];

  always @(negedge clk) begin
    int bad;
    if (started) begin
      chk("awready", 32'(awready), 32'(e_awrdy));
      chk("wready", 32'(wready), 32'(e_wrdy));
      chk("arready", 32'(arready), 32'(e_arrdy));
      chk("bvalid", 32'(bvalid), 32'(e_bvalid));
      chk("rvalid", 32'(rvalid), 32'(e_rvalid));
      chk("rdata", rdata, e_rdata);
      chk("slv_wr_stb", 32'(slv_wr_stb), 32'(e_stb));
      chk("bresp", 32'(bresp), 32'h0);
      chk("rresp", 32'(rresp), 32'h0);
      bad = -1;
      for (int i = 0; i < 16; i++) if (slv_reg[i] !== mreg[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL slv_reg[%0d]: got %h expected %h at %0t", bad, slv_reg[bad], mreg[bad], $time);
      end
      if (bvalid && bready) b_cnt++;
      for (int i = 0; i < 16; i++) if (slv_wr_stb[i]) stb_cnt[i]++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [5:0] a);
    awaddr = a; awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (awready) break;
    end
    chk("awready_within_budget", 32'(awready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (wready) break;
    end
    chk("wready_within_budget", 32'(wready), 32'h1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    fork
      do_aw(a);
      do_w(d, s);
    join
  endtask

  task automatic do_ar(input logic [5:0] a);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (arready) break;
    end
    chk("arready_within_budget", 32'(arready), 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0, s0;
    rstn = 1'b0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 1'b1; araddr = '0; arvalid = 0; rready = 1'b1;
    for (int i = 0; i < 16; i++) slv_read[i] = 32'hA000_0000 + 32'(i);
    slv_read[1] = 32'h7654_3210;

    cyc(3);
    @(negedge clk);
    chk("reset_awready", 32'(awready), 32'h0);
    chk("reset_arready", 32'(arready), 32'h0);
    chk("reset_slv_reg2", slv_reg[2], 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("awready_before_first_edge", 32'(awready), 32'h0);
    @(negedge clk);
    chk("awready_after_first_edge", 32'(awready), 32'h1);
    chk("wready_after_first_edge", 32'(wready), 32'h1);
    chk("arready_after_first_edge", 32'(arready), 32'h1);
    @(posedge clk); #1;

    // Same-cycle AW/W: commit exactly one cycle after the handshake
    b0 = b_cnt; s0 = stb_cnt[2];
    do_write(6'h08, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("reg2_before_commit", slv_reg[2], 32'h0);
    @(negedge clk);
    chk("reg2_commit", slv_reg[2], 32'hDEAD_BEEF);
    chk("stb2_commit_cycle", 32'(slv_wr_stb), 32'h0004);
    chk("bvalid_commit_cycle", 32'(bvalid), 32'h1);
    cyc(3);
    chk("stb2_pulses", 32'(stb_cnt[2] - s0), 32'h1);
    chk("b_count_first", 32'(b_cnt - b0), 32'h1);

    // W well ahead of AW
    b0 = b_cnt;
    do_w(32'h1234_5678, 4'hF);
    cyc(3);
    @(negedge clk);
    chk("reg15_waits_for_aw", slv_reg[15], 32'h0);
    chk("no_b_without_aw", 32'(bvalid), 32'h0);
    @(posedge clk); #1;
    do_aw(6'h3C);
    cyc(3);
    chk("reg15_written", slv_reg[15], 32'h1234_5678);
    chk("b_count_w_first", 32'(b_cnt - b0), 32'h1);

    // Partial strobe
    do_write(6'h10, 32'hFFFF_FFFF, 4'hF);
    cyc(2);
    do_write(6'h10, 32'h0000_0000, 4'h5);
    cyc(2);
    chk("reg4_strobe", slv_reg[4], 32'hFF00_FF00);

    // Read held under rready backpressure
    rready = 1'b0;
    do_ar(6'h04);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rdata_held", rdata, 32'h7654_3210);
      chk("rvalid_held", 32'(rvalid), 32'h1);
      chk("arready_low_held", 32'(arready), 32'h0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    cyc(2);

    // Write response backpressure blocks a second write
    bready = 1'b0;
    do_write(6'h0C, 32'h1111_1111, 4'hF);
    awaddr = 6'h14; wdata = 32'h2222_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("awready_blocked", 32'(awready), 32'h0);
      chk("wready_blocked", 32'(wready), 32'h0);
      chk("reg5_untouched", slv_reg[5], 32'h0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (awready && wready) break;
    end
    chk("second_write_accepted", 32'(awready && wready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    cyc(3);
    chk("reg3_first", slv_reg[3], 32'h1111_1111);
    chk("reg5_second", slv_reg[5], 32'h2222_2222);

    // Reset with AW held discards it
    do_aw(6'h20);
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(3);
    chk("no_bvalid_after_reset", 32'(bvalid), 32'h0);
    chk("reg8_after_reset", slv_reg[8], 32'h0);
    do_w(32'h0000_0055, 4'hF);
    cyc(3);
    chk("w_alone_no_commit", 32'(bvalid), 32'h0);
    chk("reg8_not_written", slv_reg[8], 32'h0);
    do_aw(6'h24);
    cyc(3);
    chk("reg9_after_pairing", slv_reg[9], 32'h0000_0055);

    // Random traffic, including occasional mid-transaction reset
    for (int c = 0; c < 3000; c++) begin
      rstn    = ($urandom_range(0, 299) != 0);
      awvalid = 1'($urandom_range(0, 1));
      awaddr  = 6'($urandom);
      wvalid  = 1'($urandom_range(0, 1));
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      arvalid = 1'($urandom_range(0, 1));
      araddr  = 6'($urandom);
      bready  = ($urandom_range(0, 3) != 0);
      rready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 16; i++) slv_read[i] = $urandom;
      cyc(1);
    end
    rstn = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
